// File: rtl/mc_fsm_ctrl.sv
// rtl/mc_fsm_ctrl.sv - memory controller arbitration FSM (IDLE/WR/RD/RF)
// Optional refresh timer and RF state are built only when MC_REFRESH_EN is defined.
module mc_fsm_ctrl #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_en,
  input  logic [27:0]                mc_rf_start_cfg,
  input  logic [27:0]                mc_rf_period_cfg,
  input  logic [AXI_FRAME_WIDTH-1:0] axi_frame_data,
  input  logic                       axi_frame_valid,
  output logic                       axi_frame_ready,
  output logic [AXI_DATA_WIDTH-1:0]  array_rdata,
  output logic                       array_rvalid,
  output logic [AXI_FRAME_WIDTH-1:0] axi_frame_wr_data,
  output logic                       axi_frame_wr_valid,
  input  logic                       axi_frame_wr_ready,
  input  logic                       wr_done,
  output logic [AXI_FRAME_WIDTH-1:0] axi_frame_rd_data,
  output logic                       axi_frame_rd_valid,
  input  logic                       axi_frame_rd_ready,
  input  logic                       rd_done,
  input  logic [AXI_DATA_WIDTH-1:0]  array_rd_rdata,
  input  logic                       array_rd_rvalid,
  output logic                       rf_start,
  input  logic                       rf_done,
  output logic [1:0]                 fsm_cs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RF   = 2'd3
  } state_t;

  state_t cs, ns;
  logic   eof_seen;
  logic   rf_req;
  logic   frame_sof, frame_eof, frame_rw;
  logic   eof_hs;

  assign frame_sof = axi_frame_data[AXI_FRAME_WIDTH-1];
  assign frame_eof = axi_frame_data[AXI_FRAME_WIDTH-2];
  assign frame_rw  = axi_frame_data[AXI_FRAME_WIDTH-3];

  assign axi_frame_wr_data = axi_frame_data;
  assign axi_frame_rd_data = axi_frame_data;
  assign array_rdata       = array_rd_rdata;
  assign fsm_cs            = cs;
  assign eof_hs            = axi_frame_valid && axi_frame_ready && frame_eof;

  always_comb begin
    ns                 = cs;
    axi_frame_ready    = 1'b0;
    axi_frame_wr_valid = 1'b0;
    axi_frame_rd_valid = 1'b0;
    array_rvalid       = 1'b0;
    case (cs)
      S_IDLE: begin
        // Refresh outranks a new burst; the sof beat itself is acked later
        if (rf_req)
          ns = S_RF;
        else if (mc_en && axi_frame_valid && frame_sof)
          ns = frame_rw ? S_WR : S_RD;
      end
      S_WR: begin
        if (!eof_seen) begin
          axi_frame_wr_valid = axi_frame_valid;
          axi_frame_ready    = axi_frame_wr_ready;
        end
        if (wr_done)
          ns = S_IDLE;
      end
      S_RD: begin
        if (!eof_seen) begin
          axi_frame_rd_valid = axi_frame_valid;
          axi_frame_ready    = axi_frame_rd_ready;
        end
        array_rvalid = array_rd_rvalid;
        if (rd_done)
          ns = S_IDLE;
      end
      S_RF: begin
        if (rf_done)
          ns = S_IDLE;
      end
      default: ns = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cs       <= S_IDLE;
      eof_seen <= 1'b0;
    end else begin
      cs       <= ns;
      // Cleared whenever the burst state is left, including done racing the eof beat
      eof_seen <= (cs == S_WR || cs == S_RD) && (ns == cs) && (eof_seen || eof_hs);
    end
  end

`ifdef MC_REFRESH_EN
  logic [27:0] rf_cnt;
  logic [27:0] rf_target;
  logic        rf_first_done;
  logic        rf_started;
  logic        rf_expire;

  assign rf_target = rf_first_done ? mc_rf_period_cfg : mc_rf_start_cfg;
  assign rf_expire = mc_en && (rf_target != 28'd0) && (rf_cnt == rf_target - 28'd1);
  assign rf_start  = (cs == S_RF) && !rf_started;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rf_cnt        <= 28'd0;
      rf_first_done <= 1'b0;
      rf_started    <= 1'b0;
      rf_req        <= 1'b0;
    end else begin
      rf_started <= (cs == S_RF) && (ns == S_RF);
      if (!mc_en) begin
        rf_cnt        <= 28'd0;
        rf_first_done <= 1'b0;
      end else if (rf_target != 28'd0) begin
        if (rf_expire) begin
          rf_cnt        <= 28'd0;
          rf_first_done <= 1'b1;
        end else begin
          rf_cnt <= rf_cnt + 28'd1;
        end
      end
      // An expiry while a request is still pending is dropped, not queued
      if (rf_start)
        rf_req <= 1'b0;
      else if (rf_expire)
        rf_req <= 1'b1;
    end
  end
`else
  logic unused_rf_cfg;
  assign unused_rf_cfg = ^{mc_rf_start_cfg, mc_rf_period_cfg};
  assign rf_req        = 1'b0;
  assign rf_start      = 1'b0;
`endif

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
// tb/tb_mc_fsm_ctrl.sv - directed self-checking bench for mc_fsm_ctrl
module tb_mc_fsm_ctrl;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int FW = AW + DW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mc_en;
  logic [27:0]   mc_rf_start_cfg, mc_rf_period_cfg;
  logic [FW-1:0] axi_frame_data;
  logic          axi_frame_valid, axi_frame_ready;
  logic [DW-1:0] array_rdata;
  logic          array_rvalid;
  logic [FW-1:0] axi_frame_wr_data, axi_frame_rd_data;
  logic          axi_frame_wr_valid, axi_frame_wr_ready, wr_done;
  logic          axi_frame_rd_valid, axi_frame_rd_ready, rd_done;
  logic [DW-1:0] array_rd_rdata;
  logic          array_rd_rvalid;
  logic          rf_start, rf_done;
  logic [1:0]    fsm_cs;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mc_fsm_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mc_en(mc_en),
    .mc_rf_start_cfg(mc_rf_start_cfg), .mc_rf_period_cfg(mc_rf_period_cfg),
    .axi_frame_data(axi_frame_data), .axi_frame_valid(axi_frame_valid),
    .axi_frame_ready(axi_frame_ready),
    .array_rdata(array_rdata), .array_rvalid(array_rvalid),
    .axi_frame_wr_data(axi_frame_wr_data), .axi_frame_wr_valid(axi_frame_wr_valid),
    .axi_frame_wr_ready(axi_frame_wr_ready), .wr_done(wr_done),
    .axi_frame_rd_data(axi_frame_rd_data), .axi_frame_rd_valid(axi_frame_rd_valid),
    .axi_frame_rd_ready(axi_frame_rd_ready), .rd_done(rd_done),
    .array_rd_rdata(array_rd_rdata), .array_rd_rvalid(array_rd_rvalid),
    .rf_start(rf_start), .rf_done(rf_done), .fsm_cs(fsm_cs)
  );

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [FW-1:0] mkf(input logic sof, input logic eof, input logic rw,
                                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
    return {sof, eof, rw, addr, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int hs;
    int n;
    int t1;
    int pulses;
    int rf_seen;
    logic got;

    rst_n = 1'b1; mc_en = 1'b0;
    mc_rf_start_cfg = 28'd0; mc_rf_period_cfg = 28'd0;
    axi_frame_data = mkf(1'b1, 1'b0, 1'b1, 20'h00055, 64'h1234);
    axi_frame_valid = 1'b1;
    axi_frame_wr_ready = 1'b1; axi_frame_rd_ready = 1'b1;
    wr_done = 1'b0; rd_done = 1'b0; rf_done = 1'b0;
    array_rd_rdata = 64'h0; array_rd_rvalid = 1'b1;
    tick(); tick();
    settle();
    check("rst_fsm_cs", fsm_cs, 2'd0);
    check("rst_ready", axi_frame_ready, 1'b0);
    check("rst_wr_valid", axi_frame_wr_valid, 1'b0);
    check("rst_rd_valid", axi_frame_rd_valid, 1'b0);
    check("rst_rvalid", array_rvalid, 1'b0);
    check("rst_rf_start", rf_start, 1'b0);
    check("rst_wr_data_follows", axi_frame_wr_data, mkf(1'b1, 1'b0, 1'b1, 20'h00055, 64'h1234));
    rst_n = 1'b0; axi_frame_valid = 1'b0; array_rd_rvalid = 1'b0;
    tick();

    // valid without sof in IDLE is ignored
    mc_en = 1'b1;
    axi_frame_data = mkf(1'b0, 1'b0, 1'b1, 20'd7, 64'h0);
    axi_frame_valid = 1'b1;
    settle();
    check("nosof_ready", axi_frame_ready, 1'b0);
    tick();
    check("nosof_stay_idle", fsm_cs, 2'd0);

    // write burst: ready low 4 cycles, then three beats
    axi_frame_data = mkf(1'b1, 1'b0, 1'b1, 20'd100, 64'h100);
    axi_frame_wr_ready = 1'b0;
    settle();
    check("wr_sof_not_acked_idle", axi_frame_ready, 1'b0);
    tick();
    check("wr_fsm_cs", fsm_cs, 2'd1);
    check("wr_valid_pass", axi_frame_wr_valid, 1'b1);
    check("wr_ready_low", axi_frame_ready, 1'b0);
    check("wr_data_pass", axi_frame_wr_data, mkf(1'b1, 1'b0, 1'b1, 20'd100, 64'h100));
    tick(); tick(); tick();
    check("wr_ready_still_low", axi_frame_ready, 1'b0);
    hs = 0;
    axi_frame_wr_ready = 1'b1;
    settle();
    check("wr_ready_mirror", axi_frame_ready, 1'b1);
    if (axi_frame_wr_valid && axi_frame_ready) hs++;
    tick();
    axi_frame_data = mkf(1'b0, 1'b0, 1'b1, 20'd101, 64'h101);
    settle();
    if (axi_frame_wr_valid && axi_frame_ready) hs++;
    tick();
    axi_frame_data = mkf(1'b0, 1'b1, 1'b1, 20'd102, 64'h102);
    settle();
    if (axi_frame_wr_valid && axi_frame_ready) hs++;
    tick();
    check("wr_handshakes", hs, 3);
    check("wr_after_eof_ready", axi_frame_ready, 1'b0);
    check("wr_after_eof_valid", axi_frame_wr_valid, 1'b0);
    check("wr_wait_done", fsm_cs, 2'd1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0; axi_frame_valid = 1'b0;
    check("wr_done_idle", fsm_cs, 2'd0);

    // read burst, two beats
    axi_frame_data = mkf(1'b1, 1'b0, 1'b0, 20'd200, 64'h200);
    axi_frame_valid = 1'b1;
    tick();
    check("rd_fsm_cs", fsm_cs, 2'd2);
    check("rd_valid_pass", axi_frame_rd_valid, 1'b1);
    check("rd_wr_valid_low", axi_frame_wr_valid, 1'b0);
    check("rd_ready_mirror", axi_frame_ready, 1'b1);
    array_rd_rdata = 64'hABCD; array_rd_rvalid = 1'b1;
    settle();
    check("rd_rvalid_pass", array_rvalid, 1'b1);
    check("rd_rdata_pass", array_rdata, 64'hABCD);
    tick();
    axi_frame_data = mkf(1'b0, 1'b1, 1'b0, 20'd201, 64'h201);
    settle();
    check("rd_eof_ready", axi_frame_ready, 1'b1);
    tick();
    check("rd_after_eof_valid", axi_frame_rd_valid, 1'b0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; axi_frame_valid = 1'b0;
    check("rd_done_idle", fsm_cs, 2'd0);
    check("idle_rvalid_gated", array_rvalid, 1'b0);
    array_rd_rvalid = 1'b0;

    // single-beat write with wr_done racing the eof handshake
    axi_frame_data = mkf(1'b1, 1'b1, 1'b1, 20'd300, 64'h300);
    axi_frame_valid = 1'b1;
    tick();
    check("race_in_wr", fsm_cs, 2'd1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0; axi_frame_valid = 1'b0;
    check("race_done_idle", fsm_cs, 2'd0);

    // mc_en dropped mid-burst: burst finishes, then no new burst starts
    axi_frame_data = mkf(1'b1, 1'b0, 1'b1, 20'd400, 64'h400);
    axi_frame_valid = 1'b1;
    tick();
    mc_en = 1'b0;
    settle();
    check("en_off_burst_continues", axi_frame_wr_valid, 1'b1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    tick();
    check("en_off_stays_idle", fsm_cs, 2'd0);
    mc_en = 1'b1;

    // reset while in WR
    tick();
    check("rstwr_in_wr", fsm_cs, 2'd1);
    rst_n = 1'b1;
    tick();
    check("rstwr_fsm_cs", fsm_cs, 2'd0);
    check("rstwr_ready", axi_frame_ready, 1'b0);
    check("rstwr_wr_valid", axi_frame_wr_valid, 1'b0);
    rst_n = 1'b0; axi_frame_valid = 1'b0;
    tick();

`ifdef MC_REFRESH_EN
    // first refresh after start cfg, later ones every period
    rst_n = 1'b1; mc_en = 1'b0;
    mc_rf_start_cfg = 28'd100; mc_rf_period_cfg = 28'd2400;
    tick();
    rst_n = 1'b0; mc_en = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick(); n++;
      if (rf_start) got = 1'b1;
    end
    t1 = cyc;
    check("rf_first_delay", n, 101);
    check("rf_fsm_cs", fsm_cs, 2'd3);
    tick();
    check("rf_start_one_cycle", rf_start, 1'b0);
    for (int i = 0; i < 98; i++) tick();
    rf_done = 1'b1;
    tick();
    rf_done = 1'b0;
    check("rf_done_idle", fsm_cs, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      tick();
      if (rf_start) got = 1'b1;
    end
    check("rf_period_gap", cyc - t1, 2400);
    rf_done = 1'b1;
    tick();
    rf_done = 1'b0;

    // refresh due mid-burst waits, then beats a pending sof write
    rst_n = 1'b1; mc_en = 1'b0;
    mc_rf_start_cfg = 28'd20; mc_rf_period_cfg = 28'd0;
    tick();
    rst_n = 1'b0; mc_en = 1'b1;
    axi_frame_data = mkf(1'b1, 1'b0, 1'b1, 20'd500, 64'h500);
    axi_frame_valid = 1'b1; axi_frame_wr_ready = 1'b0;
    rf_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rf_start) rf_seen++;
    end
    check("rfmid_no_interrupt", rf_seen, 0);
    check("rfmid_still_wr", fsm_cs, 2'd1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check("rfmid_idle", fsm_cs, 2'd0);
    check("rfmid_idle_no_start", rf_start, 1'b0);
    tick();
    check("rfmid_rf_wins", fsm_cs, 2'd3);
    check("rfmid_rf_start", rf_start, 1'b1);
    tick();
    rf_done = 1'b1;
    tick();
    rf_done = 1'b0;
    check("rfmid_rf_done_idle", fsm_cs, 2'd0);
    tick();
    check("rfmid_write_after_rf", fsm_cs, 2'd1);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rf_start) pulses++;
    end
    check("rf_period0_once", pulses, 0);
    wr_done = 1'b1; axi_frame_valid = 1'b0;
    tick();
    wr_done = 1'b0;
`else
    // refresh not built: configuration must have no effect
    mc_rf_start_cfg = 28'd5; mc_rf_period_cfg = 28'd5;
    pulses = 0; rf_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rf_start) pulses++;
      if (fsm_cs == 2'd3) rf_seen++;
    end
    check("norf_no_start", pulses, 0);
    check("norf_no_rf_state", rf_seen, 0);
    axi_frame_data = mkf(1'b1, 1'b0, 1'b1, 20'd600, 64'h600);
    axi_frame_valid = 1'b1;
    tick();
    check("norf_write_ok", fsm_cs, 2'd1);
    axi_frame_valid = 1'b0; wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
